// File: rtl/param_reader.sv
// Parameter-buffer read master: streams num consecutive words from base (wrapping)
// over the single-port RAM bus onto a valid/ready stream, then signals finish.
module param_reader #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter logic        WRITE_DIS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] base_i,
  input  logic [IDX_W:0]   num_i,
  output logic             finish_o,
  output logic             cs_o,
  output logic             oe_o,
  output logic [31:0]      addr_o,
  output logic             W_req_o,
  output logic [31:0]      W_data_o,
  input  logic [31:0]      R_data_i,
  output logic             param_valid_o,
  output logic [31:0]      param_data_o,
  output logic [IDX_W-1:0] param_idx_o,
  input  logic             param_ready_i
);

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_base;
  logic [IDX_W:0]   r_num;
  logic [IDX_W:0]   r_rd_cnt;
  logic             r_inflight;
  logic [IDX_W-1:0] r_inflight_idx;
  logic [31:0]      r_fifo_data [2];
  logic [IDX_W-1:0] r_fifo_idx  [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_finish;

  logic [IDX_W:0]   w_num_clamped;
  logic             w_pop;
  logic [1:0]       w_occ;
  logic             w_credit;
  logic             w_issue;
  logic             w_abort;
  logic             w_last_issue;
  logic [IDX_W-1:0] w_addr;

  assign w_num_clamped = (num_i > NUM_MAX) ? NUM_MAX : num_i;
  assign w_pop         = (r_count != 2'd0) && param_ready_i;
  assign w_occ         = r_count + 2'(r_inflight);
  // A slot freed by a same-cycle pop may be reused immediately.
  assign w_credit      = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
  assign w_issue       = (r_state == S_READ) && start_i && w_credit;
  assign w_abort       = !start_i &&
                         ((r_state == S_SYNC) || (r_state == S_READ) || (r_state == S_DRAIN));
  assign w_last_issue  = (r_rd_cnt == (r_num - (IDX_W+1)'(1)));
  assign w_addr        = r_base + r_rd_cnt[IDX_W-1:0];

  assign cs_o          = w_issue;
  assign oe_o          = w_issue;
  assign addr_o        = w_issue ? 32'(w_addr) : 32'd0;
  assign W_req_o       = WRITE_DIS;
  assign W_data_o      = 32'd0;
  assign finish_o      = r_finish;
  assign param_valid_o = (r_count != 2'd0);
  assign param_data_o  = r_fifo_data[r_rd_ptr];
  assign param_idx_o   = r_fifo_idx[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_num          <= '0;
      r_rd_cnt       <= '0;
      r_inflight     <= 1'b0;
      r_inflight_idx <= '0;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_finish       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_idx[i]  <= '0;
      end
    end else begin
      // Read-return path: the word addressed last cycle lands in the FIFO now.
      if (w_abort) begin
        r_inflight <= 1'b0;
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_count    <= 2'd0;
      end else begin
        r_inflight     <= w_issue;
        r_inflight_idx <= r_rd_cnt[IDX_W-1:0];
        if (r_inflight) begin
          r_fifo_data[r_wr_ptr] <= R_data_i;
          r_fifo_idx[r_wr_ptr]  <= r_inflight_idx;
          r_wr_ptr              <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base   <= base_i;
            r_num    <= w_num_clamped;
            r_rd_cnt <= '0;
            r_state  <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (!start_i) begin
            r_state <= S_IDLE;
          end else if (r_num == '0) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
          end else begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (!start_i) begin
            r_state <= S_IDLE;
          end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + (IDX_W+1)'(1);
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!start_i) begin
            r_state <= S_IDLE;
          end else if (w_pop && (r_count == 2'd1) && !r_inflight) begin
            r_state  <= S_DONE;
            r_finish <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start_i) begin
            r_state  <= S_IDLE;
            r_finish <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_finish <= 1'b0;
        end
      endcase
    end
  end

endmodule
